fifo_ptr_ctrl: RTL and testbench
================================

// Module: fifo_ptr_ctrl
// PURPOSE
//  Local pointer generator for one side of the async FIFO: write side (STATE=1) or read side (STATE=0).
//  - Accepts access requests and advances a binary/Gray pointer pair.
//  - Drives the RAM address and enable.
//  - Publishes the Gray pointer for the CDC synchronizer and the flag block.
//  - Computes occupancy level and an almost-flag from the synchronized remote pointer.
//  - Is the producer of the pointers the flag block consumes.
// PARAMETERS
//  STATE       0     0 = read side (empty-guarded), 1 = write side (full-guarded)
//  ADDR_WIDTH  8     pointer width incl. wrap bit; RAM depth DEPTH = 2**(ADDR_WIDTH-1)
//  ALMOST      2     almost threshold in entries, 1 <= ALMOST < DEPTH
// PORTS
//  clk          in   1             side-local clock (clk_wr for STATE=1, clk_rd for STATE=0)
//  rst_n        in   1             synchronous, active-low reset
//  req          in   1             access request (wr_en or rd_en)
//  flag_i       in   1             full (STATE=1) or empty (STATE=0) from flag block
//  ptr_rmt_gray in   ADDR_WIDTH    remote Gray pointer, already synchronized into clk
//  mem_en       out  1             RAM access strobe this cycle (combinational)
//  mem_addr     out  ADDR_WIDTH-1  RAM address = ptr_bin[ADDR_WIDTH-2:0]
//  ptr_gray     out  ADDR_WIDTH    local Gray pointer (registered); to synchronizer and flag block
//  level        out  ADDR_WIDTH    occupancy as seen from this side (registered)
//  almost       out  1             almost-full (STATE=1) or almost-empty (STATE=0) (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//  - ptr_bin, ptr_gray, level, almost, limit_r all clear to 0.
//  - mem_en=0 while rst_n=0.
//  - Reset mid-operation discards all in-flight state; the pointer restarts at 0.
//  Accept rule
//  - inc = req & ~flag_i & ~limit_r & rst_n.
//  - mem_en = inc, same cycle; mem_addr is the current registered pointer.
//  - Rejected requests are dropped; the block does not queue them.
//  Pointer update
//  - bin_nx = ptr_bin + inc, mod 2**ADDR_WIDTH; wraps naturally through the MSB.
//  - ptr_bin <= bin_nx; ptr_gray <= bin_nx ^ (bin_nx >> 1).
//  - Exactly one ptr_gray bit changes per increment.
//  - Latency req -> ptr_gray change = 1 clk.
//  Remote decode
//  - rmt_bin = Gray-to-binary of ptr_rmt_gray: b[i] = XOR of g[ADDR_WIDTH-1:i].
//  - Decode is combinational and unregistered.
//  Level (registered, uses bin_nx)
//  - STATE=1: level <= bin_nx - rmt_bin (mod 2**ADDR_WIDTH).
//  - STATE=0: level <= rmt_bin - bin_nx (mod 2**ADDR_WIDTH).
//  - Valid range 0..DEPTH.
//  Limit guard (covers the 1-cycle lag of flag_i)
//  - STATE=1: limit_r <= (bin_nx - rmt_bin) == DEPTH.
//  - STATE=0: limit_r <= (bin_nx == rmt_bin).
//  - The block never over-runs when flag_i lags; this guarantee relies on limit_r.
//  Almost flag
//  - STATE=1: almost <= level_nx >= DEPTH - ALMOST.
//  - STATE=0: almost <= level_nx <= ALMOST.
//  Other rules
//  - req held high across a limit: accepts resume the cycle after the remote pointer moves and limit_r clears.
//  - Remote pointer moves in the same cycle as a local inc: both are folded into the same level/limit update.
//  - Remote pointer is treated as monotonic. A stale synced value only makes level/limit conservative.
//  - No state machine beyond the pointer counter. Invalid STATE is flagged at elaboration.
// TESTING
//  T1 reset:
//   - rst_n=0 for 2 clk with req=1 -> mem_en=0, ptr_gray=0, level=0, almost=0.
//   - (STATE=0) almost=1 after the first clk out of reset.
//  T2 fill (STATE=1, AW=3, ALMOST=1, rmt=000, flag_i=0), req=1 for 6 clk:
//   - mem_en=1 for 4 clk; mem_addr 0,1,2,3.
//   - ptr_gray 001,011,010,110.
//   - 5th/6th cycles mem_en=0 (limit_r).
//   - level=4; almost=1 from level 3.
//  T3 wrap (STATE=1, AW=3), remote advanced to keep room, 9 accepts:
//   - ptr_gray 001,011,010,110,111,101,100,000,001.
//   - Exactly one bit toggles per step; mem_addr wraps 3->0.
//  T4 empty (STATE=0, rmt=000), req=1:
//   - mem_en=0, level=0.
//   - rmt set to 011 (bin 2) -> level=2, then 2 accepts (addr 0,1), then mem_en=0.
//  T5 flag_i=1 with limit_r=0, req=1 -> no accept, pointer unchanged.
//  T6 reset mid-stream after 3 accepts -> next clk ptr_gray=0, level=0; accepts resume at addr 0.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - local binary/Gray pointer generator for one side of an async FIFO
//
// Ports:
//   clk          side-local clock (write clock for STATE=1, read clock for STATE=0)
//   rst_n        synchronous active-low reset
//   req          access request (write enable or read enable)
//   flag_i       full (STATE=1) or empty (STATE=0) from the flag block
//   ptr_rmt_gray remote Gray pointer, already synchronized into clk
//   mem_en       RAM access strobe for this cycle (combinational)
//   mem_addr     RAM address, low bits of the local binary pointer
//   ptr_gray     registered local Gray pointer, to synchronizer and flag block
//   level        registered occupancy as seen from this side
//   almost       registered almost-full (STATE=1) / almost-empty (STATE=0)

module fifo_ptr_ctrl #(
   parameter int STATE      = 0,
   parameter int ADDR_WIDTH = 8,
   parameter int ALMOST     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  flag_i,
   input  logic [ADDR_WIDTH-1:0] ptr_rmt_gray,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-2:0] mem_addr,
   output logic [ADDR_WIDTH-1:0] ptr_gray,
   output logic [ADDR_WIDTH-1:0] level,
   output logic                  almost
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_V = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALM_V   = ADDR_WIDTH'(ALMOST);
   localparam logic [ADDR_WIDTH-1:0] HI_V    = ADDR_WIDTH'(DEPTH - ALMOST);

   generate
      if (STATE != 0 && STATE != 1) begin : g_bad_state
         $error("fifo_ptr_ctrl: STATE must be 0 (read) or 1 (write)");
      end
      if (ALMOST < 1 || ALMOST >= DEPTH) begin : g_bad_almost
         $error("fifo_ptr_ctrl: ALMOST must satisfy 1 <= ALMOST < DEPTH");
      end
   endgenerate

   logic [ADDR_WIDTH-1:0] ptr_bin;
   logic [ADDR_WIDTH-1:0] bin_nx;
   logic [ADDR_WIDTH-1:0] rmt_bin;
   logic [ADDR_WIDTH-1:0] level_nx;
   logic                  limit_r;
   logic                  limit_nx;
   logic                  almost_nx;
   logic                  inc;

   // limit_r closes the window where flag_i still lags our own last access.
   assign inc      = req & ~flag_i & ~limit_r & rst_n;
   assign mem_en   = inc;
   assign mem_addr = ptr_bin[ADDR_WIDTH-2:0];
   assign bin_nx   = ptr_bin + {{(ADDR_WIDTH-1){1'b0}}, inc};

   // Gray to binary: bit i is the XOR of all Gray bits at or above i.
   always_comb begin
      rmt_bin = '0;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         rmt_bin[i] = ^(ptr_rmt_gray >> i);
      end
   end

   // Level, limit and almost all look at the post-increment pointer so an
   // access and a remote move in the same cycle fold into one update.
   generate
      if (STATE == 1) begin : g_wr
         assign level_nx  = bin_nx - rmt_bin;
         assign limit_nx  = (level_nx == DEPTH_V);
         assign almost_nx = (level_nx >= HI_V);
      end else begin : g_rd
         assign level_nx  = rmt_bin - bin_nx;
         assign limit_nx  = (bin_nx == rmt_bin);
         assign almost_nx = (level_nx <= ALM_V);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_bin  <= '0;
         ptr_gray <= '0;
         level    <= '0;
         limit_r  <= 1'b0;
         almost   <= 1'b0;
      end else begin
         ptr_bin  <= bin_nx;
         ptr_gray <= bin_nx ^ (bin_nx >> 1);
         level    <= level_nx;
         limit_r  <= limit_nx;
         almost   <= almost_nx;
      end
   end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - self-checking bench for fifo_ptr_ctrl, write and read side instances

module tb_fifo_ptr_ctrl;

   localparam int AW = 3;

   logic clk;
   logic rst_n;
   logic w_req, w_flag, r_req, r_flag;
   logic [AW-1:0] w_rmt, r_rmt;
   logic [AW-1:0] w_rmt_gray, r_rmt_gray;
   logic w_en, r_en;
   logic [AW-2:0] w_addr, r_addr;
   logic [AW-1:0] w_gray, r_gray, w_level, r_level;
   logic w_almost, r_almost;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   // Reference model: pointers as counters, occupancy as plain differences.
   logic [AW-1:0] wp = '0, rp = '0, wlvl = '0, rlvl = '0;
   logic wlim = 0, walm = 0, rlim = 0, ralm = 0;
   logic [AW-1:0] occ_w, room_r, prev_g;

   logic [2:0] t2_en   [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
   logic [2:0] t2_addr [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
   logic [2:0] t2_gray [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b110};
   logic [2:0] t2_lvl  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
   logic [2:0] t2_alm  [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
   logic [2:0] t3_gray [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
   logic [2:0] t3_addr [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

   function automatic logic [AW-1:0] gray(input logic [AW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign w_rmt_gray = gray(w_rmt);
   assign r_rmt_gray = gray(r_rmt);

   fifo_ptr_ctrl #(.STATE(1), .ADDR_WIDTH(AW), .ALMOST(1)) u_wr (
      .clk(clk), .rst_n(rst_n), .req(w_req), .flag_i(w_flag), .ptr_rmt_gray(w_rmt_gray),
      .mem_en(w_en), .mem_addr(w_addr), .ptr_gray(w_gray), .level(w_level), .almost(w_almost)
   );

   fifo_ptr_ctrl #(.STATE(0), .ADDR_WIDTH(AW), .ALMOST(1)) u_rd (
      .clk(clk), .rst_n(rst_n), .req(r_req), .flag_i(r_flag), .ptr_rmt_gray(r_rmt_gray),
      .mem_en(r_en), .mem_addr(r_addr), .ptr_gray(r_gray), .level(r_level), .almost(r_almost)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0; w_req = 0; r_req = 0; w_flag = 0; r_flag = 1; w_rmt = '0; r_rmt = '0;
      step();
      rst_n = 1;
      step();
      r_flag = 0;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         wp = '0; wlvl = '0; wlim = 0; walm = 0;
         rp = '0; rlvl = '0; rlim = 0; ralm = 0;
      end else begin
         if (w_req && !w_flag && !wlim) wp = wp + 3'd1;
         wlvl = wp - w_rmt;
         wlim = (wlvl == 3'd4);
         walm = (wlvl >= 3'd3);
         if (r_req && !r_flag && !rlim) rp = rp + 3'd1;
         rlvl = r_rmt - rp;
         rlim = (rlvl == 3'd0);
         ralm = (rlvl <= 3'd1);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("w_mem_en",   w_en,     w_req & ~w_flag & ~wlim & rst_n);
         chk("w_mem_addr", w_addr,   wp[AW-2:0]);
         chk("w_ptr_gray", w_gray,   gray(wp));
         chk("w_level",    w_level,  wlvl);
         chk("w_almost",   w_almost, walm);
         chk("r_mem_en",   r_en,     r_req & ~r_flag & ~rlim & rst_n);
         chk("r_mem_addr", r_addr,   rp[AW-2:0]);
         chk("r_ptr_gray", r_gray,   gray(rp));
         chk("r_level",    r_level,  rlvl);
         chk("r_almost",   r_almost, ralm);
      end
   end

   initial begin
      // T1: reset with requests pending
      rst_n = 0; w_req = 1; r_req = 1; w_flag = 0; r_flag = 1; w_rmt = '0; r_rmt = '0;
      step();
      chk_en = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t1_w_mem_en", w_en, 0);   chk("t1_r_mem_en", r_en, 0);
         chk("t1_w_gray", w_gray, 0);   chk("t1_w_level", w_level, 0);
         chk("t1_w_almost", w_almost, 0); chk("t1_r_almost", r_almost, 0);
         step();
      end
      rst_n = 1; w_req = 0;
      step();
      @(negedge clk);
      chk("t1_r_almost_after", r_almost, 1);
      chk("t1_r_level_after", r_level, 0);

      // T4: read side empty, then remote advances by two
      r_flag = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t4_empty_en", r_en, 0);
         chk("t4_empty_level", r_level, 0);
         step();
      end
      r_rmt = 3'd2;
      @(negedge clk); chk("t4_a_en", r_en, 0); step();
      @(negedge clk); chk("t4_b_level", r_level, 2); chk("t4_b_en", r_en, 1); chk("t4_b_addr", r_addr, 0); step();
      @(negedge clk); chk("t4_c_en", r_en, 1); chk("t4_c_addr", r_addr, 1); step();
      @(negedge clk); chk("t4_d_en", r_en, 0); chk("t4_d_level", r_level, 0);
      r_req = 0;
      step();

      // T2: write side fill against a parked remote
      w_req = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t2_en", w_en, t2_en[k]);
         chk("t2_addr", w_addr, t2_addr[k]);
         chk("t2_gray", w_gray, t2_gray[k]);
         chk("t2_level", w_level, t2_lvl[k]);
         chk("t2_almost", w_almost, t2_alm[k]);
         step();
      end
      @(negedge clk);
      chk("t2_final_level", w_level, 4);
      chk("t2_final_en", w_en, 0);

      // T3: wrap with the remote following closely
      do_reset();
      w_req = 1;
      prev_g = '0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("t3_en", w_en, 1);
         chk("t3_addr", w_addr, t3_addr[k]);
         if (k > 0) begin
            chk("t3_gray", w_gray, t3_gray[k-1]);
            chk("t3_one_bit", $countones(w_gray ^ prev_g), 1);
         end
         prev_g = w_gray;
         step();
         w_rmt = wp;
      end
      @(negedge clk);
      chk("t3_gray_last", w_gray, t3_gray[8]);
      chk("t3_one_bit_last", $countones(w_gray ^ prev_g), 1);

      // T5: flag blocks accepts even with the limit clear
      do_reset();
      w_req = 1; w_flag = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t5_en", w_en, 0);
         step();
      end
      @(negedge clk);
      chk("t5_gray", w_gray, 0);
      w_flag = 0; w_req = 0;
      step();

      // T6: reset mid-stream
      do_reset();
      w_req = 1;
      repeat (3) step();
      @(negedge clk); chk("t6_gray_before", w_gray, 3'b010);
      rst_n = 0;
      @(negedge clk); chk("t6_en_in_reset", w_en, 0);
      step();
      rst_n = 1;
      @(negedge clk);
      chk("t6_gray", w_gray, 0); chk("t6_level", w_level, 0);
      chk("t6_en", w_en, 1);     chk("t6_addr", w_addr, 0);
      step();
      w_req = 0;

      // Randomized traffic with occasional resets
      do_reset();
      repeat (3000) begin
         if (!rst_n) begin
            rst_n = 1; r_flag = 1;
         end else if ($urandom_range(0, 249) == 0) begin
            rst_n = 0; w_rmt = '0; r_rmt = '0; r_flag = 1;
         end else begin
            w_req  = ($urandom_range(0, 3) != 0);
            w_flag = ($urandom_range(0, 7) == 0);
            occ_w  = wp - w_rmt;
            if (occ_w != 0 && $urandom_range(0, 2) != 0) w_rmt = w_rmt + 3'd1;
            r_req  = ($urandom_range(0, 3) != 0);
            r_flag = ($urandom_range(0, 7) == 0);
            room_r = r_rmt - rp;
            if (room_r < 3'd4 && $urandom_range(0, 1) != 0) r_rmt = r_rmt + 3'd1;
         end
         step();
      end

      @(negedge clk);
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
